// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receiver
package uart_rx_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } rx_state_t;

   // Parity bit the transmitter should have sent for a word whose XOR-reduction is data_xor
   function automatic logic expected_parity(input logic data_xor, input logic ptype);
      return (ptype == PARITY_ODD) ? ~data_xor : data_xor;
   endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// rtl/edge_bit_counter.sv - per-bit edge counter and data bit counter for the UART receiver
module edge_bit_counter
   import uart_rx_pkg::*;
#(
   parameter int BIT_COUNT_WIDTH = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [4:0]                 prescale,
   input  logic                       hold,
   input  logic                       clear_bits,
   input  logic                       bit_advance,
   output logic [4:0]                 edge_count,
   output logic [BIT_COUNT_WIDTH-1:0] bit_count,
   output logic                       bit_end
);

   // The last oversampling edge of the current bit period
   assign bit_end = (edge_count == (prescale - 5'd1));

   // Edge index within the bit; the idle cycle that sees the line low is edge 0 of the start bit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         edge_count <= 5'd0;
      end else if (hold) begin
         edge_count <= 5'd0;
      end else if (bit_end) begin
         edge_count <= 5'd0;
      end else begin
         edge_count <= edge_count + 5'd1;
      end
   end

   // Number of data bits already captured in the current frame
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_count <= '0;
      end else if (clear_bits) begin
         bit_count <= '0;
      end else if (bit_advance) begin
         bit_count <= bit_count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_controller.sv
// rtl/uart_rx_controller.sv - UART receive FSM with parity and stop-bit checking
module uart_rx_controller
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  serial_data,
   input  logic [4:0]            prescale,
   input  logic                  parity_enable,
   input  logic                  parity_type,
   input  logic                  sampled_bit,
   output logic                  sampler_enable,
   output logic [4:0]            edge_count,
   output logic [DATA_WIDTH-1:0] parallel_data,
   output logic                  data_valid,
   output logic                  parity_error,
   output logic                  framing_error
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   rx_state_t             state;
   rx_state_t             state_next;
   logic [4:0]            prescale_lat;
   logic                  parity_enable_lat;
   logic                  parity_type_lat;
   logic [DATA_WIDTH-1:0] shift_data;
   logic                  par_err;
   logic [BW-1:0]         bit_count;
   logic                  bit_end;
   logic                  in_idle;
   logic                  start_detect;

   assign in_idle        = (state == IDLE);
   assign start_detect   = in_idle && !serial_data;
   assign sampler_enable = !in_idle;

   edge_bit_counter #(
      .BIT_COUNT_WIDTH (BW)
   ) u_counter (
      .clk         (clk),
      .reset       (reset),
      .prescale    (prescale_lat),
      .hold        (in_idle && serial_data),
      .clear_bits  (in_idle),
      .bit_advance ((state == DATA) && bit_end),
      .edge_count  (edge_count),
      .bit_count   (bit_count),
      .bit_end     (bit_end)
   );

   // Frame sequencing; every transition out of a bit state happens on its last edge
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!serial_data) state_next = START;
         START:   if (bit_end) state_next = sampled_bit ? IDLE : DATA;
         DATA:    if (bit_end && (bit_count == LAST_BIT))
                     state_next = parity_enable_lat ? PARITY : STOP;
         PARITY:  if (bit_end) state_next = STOP;
         STOP:    if (bit_end) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Frame configuration is frozen when the start bit is first seen
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prescale_lat      <= 5'd16;
         parity_enable_lat <= 1'b0;
         parity_type_lat   <= PARITY_EVEN;
      end else if (start_detect) begin
         prescale_lat      <= prescale;
         parity_enable_lat <= parity_enable;
         parity_type_lat   <= parity_type;
      end
   end

   // LSB-first capture: each new bit enters at the top, so after the last bit the first sits at bit 0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift_data <= '0;
      end else if ((state == DATA) && bit_end) begin
         shift_data <= (shift_data >> 1) | (DATA_WIDTH'(sampled_bit) << (DATA_WIDTH - 1));
      end
   end

   // Parity verdict is held until the stop bit decides which pulse to emit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         par_err <= 1'b0;
      end else if (start_detect) begin
         par_err <= 1'b0;
      end else if ((state == PARITY) && bit_end) begin
         par_err <= (sampled_bit != expected_parity(^shift_data, parity_type_lat));
      end
   end

   // Exactly one outcome per completed frame; framing beats parity, and errored words are dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parallel_data <= '0;
         data_valid    <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         data_valid    <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
         if ((state == STOP) && bit_end) begin
            if (!sampled_bit) begin
               framing_error <= 1'b1;
            end else if (par_err) begin
               parity_error <= 1'b1;
            end else begin
               parallel_data <= shift_data;
               data_valid    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_controller.sv
// tb/tb_uart_rx_controller.sv - randomized self-checking bench for uart_rx_controller
module tb_uart_rx_controller;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          serial_data;
   logic [4:0]    prescale;
   logic          parity_enable;
   logic          parity_type;
   logic          sampled_bit;
   logic          sampler_enable;
   logic [4:0]    edge_count;
   logic [DW-1:0] parallel_data;
   logic          data_valid;
   logic          parity_error;
   logic          framing_error;

   uart_rx_controller #(
      .DATA_WIDTH (DW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .serial_data    (serial_data),
      .prescale       (prescale),
      .parity_enable  (parity_enable),
      .parity_type    (parity_type),
      .sampled_bit    (sampled_bit),
      .sampler_enable (sampler_enable),
      .edge_count     (edge_count),
      .parallel_data  (parallel_data),
      .data_valid     (data_valid),
      .parity_error   (parity_error),
      .framing_error  (framing_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      int            kind;   // 0 good word, 1 parity error, 2 framing error
      logic [DW-1:0] data;
   } evt_t;

   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   evt_t          exp_q[$];
   evt_t          obs_q[$];
   logic [DW-1:0] exp_pd = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Record every output pulse with the cycle it appeared in
   always @(negedge clk) begin
      evt_t e;
      if (reset && (data_valid || parity_error || framing_error)) begin
         check_eq("pulse_exclusive",
                  32'(data_valid) + 32'(parity_error) + 32'(framing_error), 32'd1);
         e.cyc  = cyc;
         e.kind = data_valid ? 0 : (parity_error ? 1 : 2);
         e.data = parallel_data;
         obs_q.push_back(e);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Ideal sampler: the voted bit equals the line value held over the whole bit period
   task automatic set_line(input logic v);
      serial_data = v;
      sampled_bit = v;
   endtask

   // Drive one frame starting this cycle and predict its outcome from the line protocol
   task automatic send_frame(input logic [DW-1:0] d, input int ps, input bit pen,
                             input bit ptype, input bit bad_par, input bit bad_stop);
      int   start;
      logic bits[$];
      evt_t e;
      start         = cyc;
      prescale      = 5'(ps);
      parity_enable = pen;
      parity_type   = ptype;
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) bits.push_back(d[i]);
      if (pen) bits.push_back((^d) ^ ptype ^ bad_par);
      bits.push_back(!bad_stop);
      for (int k = 0; k < bits.size(); k++) begin
         set_line(bits[k]);
         tick(ps);
         if (k == 0) begin
            prescale      = (ps == 8) ? 5'd16 : 5'd8;
            parity_enable = !pen;
            parity_type   = !ptype;
         end
      end
      set_line(1'b1);
      e.cyc = start + bits.size() * ps;
      if (bad_stop) begin
         e.kind = 2;
      end else if (pen && bad_par) begin
         e.kind = 1;
      end else begin
         e.kind = 0;
         exp_pd = d;
      end
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic compare_events(input string tag);
      evt_t x;
      evt_t o;
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         check_eq({tag, "_present"}, 32'(obs_q.size() > 0), 32'd1);
         if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            check_eq({tag, "_cycle"}, o.cyc, x.cyc);
            check_eq({tag, "_kind"}, o.kind, x.kind);
            if (x.kind == 0) check_eq({tag, "_data"}, 32'(o.data), 32'(x.data));
         end
      end
      check_eq({tag, "_extra"}, 32'(obs_q.size()), 32'd0);
      obs_q.delete();
      check_eq({tag, "_parallel_data"}, 32'(parallel_data), 32'(exp_pd));
   endtask

   initial begin
      reset         = 1'b0;
      prescale      = 5'd8;
      parity_enable = 1'b0;
      parity_type   = 1'b0;
      set_line(1'b1);
      tick(3);
      check_eq("rst_data_valid", 32'(data_valid), 32'd0);
      check_eq("rst_parity_error", 32'(parity_error), 32'd0);
      check_eq("rst_framing_error", 32'(framing_error), 32'd0);
      check_eq("rst_sampler_enable", 32'(sampler_enable), 32'd0);
      check_eq("rst_edge_count", 32'(edge_count), 32'd0);
      check_eq("rst_parallel_data", 32'(parallel_data), 32'd0);
      reset = 1'b1;
      tick(3);

      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(3);
      compare_events("a5_ps8");

      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(3);
      compare_events("3c_even_good");
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(3);
      compare_events("3c_even_bad");

      send_frame(8'h81, 8, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(3);
      compare_events("81_framing");

      prescale      = 5'd8;
      parity_enable = 1'b0;
      set_line(1'b0);
      tick(3);
      set_line(1'b1);
      tick(12);
      check_eq("glitch_sampler_enable", 32'(sampler_enable), 32'd0);
      check_eq("glitch_edge_count", 32'(edge_count), 32'd0);
      compare_events("glitch");

      prescale      = 5'd8;
      parity_enable = 1'b0;
      set_line(1'b0);
      tick(30);
      check_eq("mid_data_sampler_enable", 32'(sampler_enable), 32'd1);
      #2 reset = 1'b0;
      #1;
      check_eq("mid_rst_sampler_enable", 32'(sampler_enable), 32'd0);
      check_eq("mid_rst_edge_count", 32'(edge_count), 32'd0);
      check_eq("mid_rst_parallel_data", 32'(parallel_data), 32'd0);
      check_eq("mid_rst_pulses", 32'({data_valid, parity_error, framing_error}), 32'd0);
      set_line(1'b1);
      exp_pd = '0;
      tick(2);
      reset = 1'b1;
      tick(2);
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(3);
      compare_events("55_after_reset");

      send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(3);
      compare_events("back_to_back");

      for (int n = 0; n < 24; n++) begin
         logic [DW-1:0] d;
         int            ps;
         d  = DW'($urandom);
         ps = ($urandom_range(0, 1) != 0) ? 16 : 8;
         send_frame(d, ps, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
         if ($urandom_range(0, 1) != 0) tick($urandom_range(1, 5));
      end
      tick(3);
      compare_events("random");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
